test_value_uart_tx: RTL and testbench

TEST_VALUE_UART_TX -- requirements
Module: test_value_uart_tx

---
 rtl/test_value_uart_tx.sv | 199 +++++++++++++++++++
 tb/tb_test_value_uart_tx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_value_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : test_value_uart_tx
// Description : Serialises a monitored test_value word over a UART line,
//               LSB byte first, whenever it changes or a resend is requested.
//               Optional even-parity bit per byte with TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module test_value_uart_tx #(
    parameter int mem_width    = 32,
    parameter int clks_per_bit = 434
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [mem_width-1:0] test_value,
    input  logic                 send_req,
    output logic                 tx,
    output logic                 busy,
    output logic [15:0]          word_cnt
);

    localparam int                c_num_bytes = mem_width / 8;
    localparam int                c_idx_w     = (c_num_bytes > 1) ? $clog2(c_num_bytes) : 1;
    localparam logic [15:0]       c_baud_last = 16'(clks_per_bit - 1);
    localparam logic [c_idx_w-1:0] c_last_byte = c_idx_w'(c_num_bytes - 1);

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_tx_nxt;
    logic [mem_width-1:0]  r_shift;
    logic [mem_width-1:0]  r_last_sent;
    logic                  r_pending;
    logic [c_idx_w-1:0]    r_byte_idx;
    logic [2:0]            r_bit_cnt;
    logic [15:0]           r_baud_cnt;
    logic                  r_tx;
    logic                  r_busy;
    logic [15:0]           r_word_cnt;
`ifdef TX_PARITY_EN
    logic                  r_parity;
`endif

    logic w_trigger;
    logic w_bit_done;
    logic w_last_byte;

    assign w_trigger   = (r_state == S_IDLE) && ((test_value != r_last_sent) || r_pending);
    assign w_bit_done  = (r_baud_cnt == c_baud_last);
    assign w_last_byte = (r_byte_idx == c_last_byte);

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign word_cnt = r_word_cnt;

    // The shift buffer always presents the current data bit at position 0.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_trigger) begin
                    w_state_nxt = S_START;
                    w_tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    if (r_bit_cnt == 3'd7) begin
`ifdef TX_PARITY_EN
                        w_state_nxt = S_PARITY;
                        w_tx_nxt    = r_parity ^ r_shift[0];
`else
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_tx_nxt = r_shift[1];
                    end
                end
            end
`ifdef TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_done) begin
                    w_state_nxt = S_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_done) begin
                    if (w_last_byte) begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = S_START;
                        w_tx_nxt    = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift     <= '0;
            r_last_sent <= '0;
            r_pending   <= 1'b0;
            r_byte_idx  <= '0;
            r_bit_cnt   <= 3'd0;
            r_baud_cnt  <= 16'd0;
            r_busy      <= 1'b0;
            r_word_cnt  <= 16'd0;
`ifdef TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            if ((r_state == S_IDLE) || w_bit_done) begin
                r_baud_cnt <= 16'd0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 16'd1;
            end

            // A request coinciding with a trigger is served by that trigger.
            if (w_trigger) begin
                r_shift     <= test_value;
                r_last_sent <= test_value;
                r_pending   <= 1'b0;
                r_byte_idx  <= '0;
                r_bit_cnt   <= 3'd0;
                r_busy      <= 1'b1;
            end else if (send_req) begin
                r_pending <= 1'b1;
            end

`ifdef TX_PARITY_EN
            if ((r_state == S_START) && w_bit_done) begin
                r_parity <= 1'b0;
            end
`endif

            if ((r_state == S_DATA) && w_bit_done) begin
                r_shift   <= r_shift >> 1;
                r_bit_cnt <= r_bit_cnt + 3'd1;
`ifdef TX_PARITY_EN
                r_parity  <= r_parity ^ r_shift[0];
`endif
            end

            if ((r_state == S_STOP) && w_bit_done) begin
                if (w_last_byte) begin
                    r_busy     <= 1'b0;
                    r_word_cnt <= r_word_cnt + 16'd1;
                end else begin
                    r_byte_idx <= r_byte_idx + c_idx_w'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_test_value_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_value_uart_tx
// Description : Self-checking bench for test_value_uart_tx (32-bit, 4 clk/bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_value_uart_tx;

    localparam int CPB = 4;
`ifdef TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] test_value;
    logic        send_req;
    logic        tx;
    logic        busy;
    logic [15:0] word_cnt;

    int checks = 0;
    int errors = 0;

    test_value_uart_tx #(.mem_width(32), .clks_per_bit(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .test_value (test_value),
        .send_req   (send_req),
        .tx         (tx),
        .busy       (busy),
        .word_cnt   (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] value;
        logic [31:0] exp_word;
        logic [3:0]  exp_par;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Samples each bit in its third cycle, starting from the first cycle of a start bit.
    task automatic recv_word(output logic [31:0] w, output logic [3:0] par, output bit ok);
        int t;
        ok = 1'b1; w = '0; par = '0; t = 0;
        while (tx !== 1'b0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (tx !== 1'b0) begin
            ok = 1'b0;
        end else begin
            repeat (2) @(negedge clk);
            for (int b = 0; b < 4; b++) begin
                for (int k = 0; k < FB; k++) begin
                    if (!(b == 0 && k == 0)) repeat (CPB) @(negedge clk);
                    if (k == 0) begin
                        if (tx !== 1'b0) ok = 1'b0;
                    end else if (k <= 8) begin
                        w[8*b+k-1] = tx;
                    end else if (k == FB-1) begin
                        if (tx !== 1'b1) ok = 1'b0;
                    end else begin
                        par[b] = tx;
                    end
                end
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        int t;
        t = 0;
        while (busy === 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic watch_quiet(input int n, output bit started);
        started = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) started = 1'b1;
        end
    endtask

    task automatic pulse_req();
        send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
    endtask

    task automatic get_and_check(input string name, input logic [31:0] exp);
        logic [31:0] w;
        logic [3:0]  p;
        bit          ok;
        recv_word(w, p, ok);
        check({name, "_frame"}, 32'(ok), 32'd1);
        check({name, "_word"}, w, exp);
    endtask

    vec_t        vecs[6];
    logic [31:0] w;
    logic [3:0]  p;
    bit          ok;
    bit          ok2;
    bit          quiet;
    int          bc;
    int          t;
    logic [15:0] exp_cnt;

    initial begin
        vecs[0] = '{value: 32'hDEADBEEF, exp_word: 32'hDEADBEEF, exp_par: 4'b0101};
        vecs[1] = '{value: 32'hFFFFFFFF, exp_word: 32'hFFFFFFFF, exp_par: 4'b0000};
        vecs[2] = '{value: 32'h80000001, exp_word: 32'h80000001, exp_par: 4'b1001};
        vecs[3] = '{value: 32'h00000703, exp_word: 32'h00000703, exp_par: 4'b0010};
        vecs[4] = '{value: 32'h00000000, exp_word: 32'h00000000, exp_par: 4'b0000};
        vecs[5] = '{value: 32'h3C0FF0C3, exp_word: 32'h3C0FF0C3, exp_par: 4'b0000};

        rst = 1'b1; test_value = 32'h0; send_req = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_cnt", 32'(word_cnt), 32'd0);
        rst = 1'b0;
        watch_quiet(10, quiet);
        check("idle_zero_quiet", 32'(quiet), 32'd0);

        // Basic word: start bit one cycle after the change, busy for the whole word.
        test_value = 32'h000000A5;
        check("trigger_tx_same_cycle", 32'(tx), 32'd1);
        @(negedge clk);
        check("start_one_cycle_later", 32'(tx), 32'd0);
        fork
            recv_word(w, p, ok);
            begin
                bc = 0; t = 0;
                while (busy === 1'b1 && t < 2000) begin
                    bc++;
                    @(negedge clk);
                    t++;
                end
            end
        join
        check("basic_frame", 32'(ok), 32'd1);
        check("basic_word", w, 32'h000000A5);
        check("basic_busy_cycles", 32'(bc), 32'(4*FB*CPB));
        wait_idle(ok);
        check("basic_cnt", 32'(word_cnt), 32'd1);
        exp_cnt = 16'd1;

        for (int i = 0; i < 6; i++) begin
            test_value = vecs[i].value;
            recv_word(w, p, ok);
            check($sformatf("vec%0d_frame", i), 32'(ok), 32'd1);
            check($sformatf("vec%0d_word", i), w, vecs[i].exp_word);
`ifdef TX_PARITY_EN
            check($sformatf("vec%0d_parity", i), 32'(p), 32'(vecs[i].exp_par));
`endif
            wait_idle(ok);
            exp_cnt = exp_cnt + 16'd1;
            check($sformatf("vec%0d_cnt", i), 32'(word_cnt), 32'(exp_cnt));
        end

        // send_req together with a trigger yields a single word.
        test_value = 32'h5A5A5A5A;
        send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
        get_and_check("absorb", 32'h5A5A5A5A);
        wait_idle(ok);
        watch_quiet(60, quiet);
        check("absorb_no_resend", 32'(quiet), 32'd0);
        exp_cnt = exp_cnt + 16'd1;
        check("absorb_cnt", 32'(word_cnt), 32'(exp_cnt));

        // Changes while busy: the intermediate value is dropped.
        test_value = 32'h11111111;
        fork
            begin
                get_and_check("chg_first", 32'h11111111);
                get_and_check("chg_second", 32'h33333333);
            end
            begin
                repeat (20) @(negedge clk);
                test_value = 32'h22222222;
                repeat (40) @(negedge clk);
                test_value = 32'h33333333;
            end
        join
        wait_idle(ok);
        watch_quiet(60, quiet);
        check("chg_quiet", 32'(quiet), 32'd0);
        exp_cnt = exp_cnt + 16'd2;
        check("chg_cnt", 32'(word_cnt), 32'(exp_cnt));

        // Several requests while busy collapse into one resend.
        test_value = 32'h12345678;
        fork
            begin
                get_and_check("req_first", 32'h12345678);
                get_and_check("req_resend", 32'h12345678);
            end
            begin
                repeat (10) @(negedge clk);
                pulse_req();
                repeat (20) @(negedge clk);
                pulse_req();
                repeat (20) @(negedge clk);
                pulse_req();
            end
        join
        wait_idle(ok);
        watch_quiet(60, quiet);
        check("req_quiet", 32'(quiet), 32'd0);
        exp_cnt = exp_cnt + 16'd2;
        check("req_cnt", 32'(word_cnt), 32'(exp_cnt));

        // Request in idle with an unchanged value.
        pulse_req();
        get_and_check("idle_req", 32'h12345678);
        wait_idle(ok);
        exp_cnt = exp_cnt + 16'd1;
        check("idle_req_cnt", 32'(word_cnt), 32'(exp_cnt));

        // Reset during byte 2, then full retransmission from byte 0.
        test_value = 32'hCAFEF00D;
        @(negedge clk);
        repeat (100) @(negedge clk);
        check("midrst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cnt", 32'(word_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        get_and_check("midrst_resend", 32'hCAFEF00D);
        wait_idle(ok);
        check("midrst_after_cnt", 32'(word_cnt), 32'd1);

        // Counter wrap.
        @(negedge clk);
        force dut.r_word_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_word_cnt;
        @(negedge clk);
        test_value = 32'h0BADC0DE;
        get_and_check("wrap", 32'h0BADC0DE);
        wait_idle(ok2);
        check("wrap_idle", 32'(ok2), 32'd1);
        check("wrap_cnt", 32'(word_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
